// File: rtl/vector_accumulator.sv
// Accumulates a run of len operand beats into a widened sum.
// Each operand is sign- or zero-extended according to the mode latched at start.
module vector_accumulator #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  input  logic               signed_mode,
  input  logic               abort,
  input  logic [N-1:0]       a_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N+CNT_W-1:0] result_out,
  output logic               done,
  output logic               busy
);

  localparam int W = N + CNT_W;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] len_reg, len_next;
  logic             signed_reg, signed_next;
  logic [W-1:0]     acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [W-1:0]     result_reg, result_next;
  logic             done_reg, done_next;

  logic [W-1:0]     a_ext;
  logic [W-1:0]     sum;
  logic [CNT_W-1:0] cnt_inc;

  assign a_ext   = {{CNT_W{signed_reg & a_in[N-1]}}, a_in};
  assign sum     = acc_reg + a_ext;
  assign cnt_inc = cnt_reg + 1'b1;

  assign in_ready   = (state_reg == ACCUM);
  assign busy       = (state_reg == ACCUM);
  assign result_out = result_reg;
  assign done       = done_reg;

  always_comb begin
    state_next  = state_reg;
    len_next    = len_reg;
    signed_next = signed_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_next  = ACCUM;
            len_next    = len;
            signed_next = signed_mode;
            acc_next    = '0;
            cnt_next    = '0;
          end else begin
            // An empty run completes immediately with a zero sum.
            result_next = '0;
            done_next   = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (abort) begin
          state_next = IDLE;
        end else if (in_valid) begin
          if (cnt_inc == len_reg) begin
            result_next = sum;
            done_next   = 1'b1;
            state_next  = IDLE;
          end else begin
            acc_next = sum;
            cnt_next = cnt_inc;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      len_reg    <= '0;
      signed_reg <= 1'b0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      len_reg    <= len_next;
      signed_reg <= signed_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      done_reg   <= done_next;
    end
  end

endmodule

// File: tb/tb_vector_accumulator.sv
// Directed bench for vector_accumulator (N=8, CNT_W=4) with hand-computed sums.
module tb_vector_accumulator;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  len;
  logic        signed_mode;
  logic        abort;
  logic [7:0]  a_in;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] result_out;
  logic        done;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;
  int done_cnt;

  vector_accumulator #(.N(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .signed_mode(signed_mode), .abort(abort), .a_in(a_in),
    .in_valid(in_valid), .in_ready(in_ready), .result_out(result_out),
    .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] v);
    in_valid = 1'b1;
    a_in     = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic begin_run(input logic [3:0] l, input logic s);
    start = 1'b1; len = l; signed_mode = s;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; len = '0; signed_mode = 1'b0;
    abort = 1'b0; a_in = '0; in_valid = 1'b0;
    #2;
    tick(); tick();
    chk("reset_result", result_out, 12'h000);
    chk("reset_done", {11'b0, done}, 12'd0);
    chk("reset_busy", {11'b0, busy}, 12'd0);
    chk("reset_ready", {11'b0, in_ready}, 12'd0);
    reset = 1'b1;
    tick();

    // Unsigned 255 x3 back-to-back
    begin_run(4'd3, 1'b0);
    chk("u3_busy", {11'b0, busy}, 12'd1);
    chk("u3_ready", {11'b0, in_ready}, 12'd1);
    in_valid = 1'b1; a_in = 8'hFF;
    tick();
    tick();
    chk("u3_no_early_done", {11'b0, done}, 12'd0);
    tick();
    in_valid = 1'b0;
    chk("u3_done", {11'b0, done}, 12'd1);
    chk("u3_result", result_out, 12'h2FD);
    chk("u3_idle", {11'b0, busy}, 12'd0);
    tick();
    chk("u3_done_one_cycle", {11'b0, done}, 12'd0);
    chk("u3_hold", result_out, 12'h2FD);

    // Signed 0x80 + 0xFF = -129
    begin_run(4'd2, 1'b1);
    beat(8'h80);
    beat(8'hFF);
    chk("s2_done", {11'b0, done}, 12'd1);
    chk("s2_result", result_out, 12'hF7F);
    tick();

    // Same beats unsigned = 383
    begin_run(4'd2, 1'b0);
    beat(8'h80);
    beat(8'hFF);
    chk("u2_result", result_out, 12'h17F);
    tick();

    // len=15, valid every other cycle, stray start mid-run must be ignored
    begin_run(4'd15, 1'b0);
    done_cnt = 0;
    a_in = 8'hFF;
    for (int i = 0; i < 29; i++) begin
      in_valid = (i % 2 == 0);
      start    = (i == 4);
      len      = (i == 4) ? 4'd1 : 4'd15;
      tick();
      if (done) done_cnt++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk("u15_result", result_out, 12'hEF1);
    chk("u15_done_last_beat", {11'b0, done}, 12'd1);
    tick();
    if (done) done_cnt++;
    chk("u15_done_count", done_cnt[11:0], 12'd1);

    // len=0: immediate done, zero result, never busy
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0;
    chk("z_done", {11'b0, done}, 12'd1);
    chk("z_result", result_out, 12'h000);
    chk("z_busy", {11'b0, busy}, 12'd0);
    tick();
    chk("z_done_clear", {11'b0, done}, 12'd0);
    chk("z_busy2", {11'b0, busy}, 12'd0);

    // Establish a nonzero prior result, then abort mid-run
    begin_run(4'd1, 1'b0);
    beat(8'd9);
    chk("l1_result", result_out, 12'd9);
    tick();
    begin_run(4'd4, 1'b0);
    beat(8'd1);
    beat(8'd2);
    abort = 1'b1; in_valid = 1'b1; a_in = 8'd3;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("ab_busy", {11'b0, busy}, 12'd0);
    chk("ab_no_done", {11'b0, done}, 12'd0);
    chk("ab_result_kept", result_out, 12'd9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_idle_no_effect", {11'b0, done}, 12'd0);
    chk("ab_idle_result", result_out, 12'd9);
    begin_run(4'd1, 1'b0);
    beat(8'd7);
    chk("ab_next_result", result_out, 12'd7);
    chk("ab_next_done", {11'b0, done}, 12'd1);

    // Back-to-back start in the done cycle, then reset mid-run
    begin_run(4'd2, 1'b0);
    chk("b2b_busy", {11'b0, busy}, 12'd1);
    beat(8'd5);
    reset = 1'b0; in_valid = 1'b1; a_in = 8'd5;
    tick();
    in_valid = 1'b0;
    chk("rst_result", result_out, 12'h000);
    chk("rst_done", {11'b0, done}, 12'd0);
    chk("rst_busy", {11'b0, busy}, 12'd0);
    chk("rst_ready", {11'b0, in_ready}, 12'd0);
    reset = 1'b1;
    tick();
    chk("rst_after_done", {11'b0, done}, 12'd0);
    begin_run(4'd2, 1'b0);
    beat(8'd1);
    beat(8'd2);
    chk("fresh_result", result_out, 12'd3);
    chk("fresh_done", {11'b0, done}, 12'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
